conv_fc_layer: RTL and testbench

CONV_FC_LAYER -- requirements
Module: conv_fc_layer

---
 rtl/conv_fc_layer.sv | 207 ++++++++++++++++++++
 tb/tb_conv_fc_layer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_fc_layer.sv
// rtl/conv_fc_layer.sv - 1-D convolution followed by a fully connected layer, one MAC per cycle
//
// Purpose: latches an input matrix (INPUT_LAYER_HEIGHT x KERNEL_WIDTH words),
// slides a KERNEL_HEIGHT x KERNEL_WIDTH kernel down the rows to form CONV_OUT
// values, then feeds those into LAYER_HEIGHT neurons. Fixed-point, signed,
// N_SIZE fraction bits, results floored and saturated to WORD_SIZE.
//
// Ports:
//   clk_i, reset_i           clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o/data_i   input vector handshake, word r*KERNEL_WIDTH+c = x[r][c]
//   valid_o/yumi_i/data_o    result handshake, word n = neuron n
//   w_en_i/mem_addr_i/mem_data_i  weight/bias write port, address {select, index}
module conv_fc_layer #(
    parameter int WORD_SIZE          = 16,
    parameter int N_SIZE             = 2,
    parameter int INPUT_LAYER_HEIGHT = 5,
    parameter int KERNEL_HEIGHT      = 3,
    parameter int KERNEL_WIDTH       = 2,
    parameter int LAYER_HEIGHT       = 2,
    parameter int RAM_SELECT_BITS    = $clog2(LAYER_HEIGHT + 1),
    parameter int RAM_ADDRESS_BITS   = $clog2(((KERNEL_HEIGHT * KERNEL_WIDTH) >
                                               (INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1) ?
                                               (KERNEL_HEIGHT * KERNEL_WIDTH) :
                                               (INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1)) + 1)
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic                                                 valid_i,
    output logic                                                 ready_o,
    input  logic [INPUT_LAYER_HEIGHT*KERNEL_WIDTH*WORD_SIZE-1:0] data_i,
    output logic                                                 valid_o,
    input  logic                                                 yumi_i,
    output logic [LAYER_HEIGHT*WORD_SIZE-1:0]                    data_o,
    input  logic                                                 w_en_i,
    input  logic [RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0]          mem_addr_i,
    input  logic [WORD_SIZE-1:0]                                 mem_data_i
);

    localparam int CONV_OUT = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
    localparam int K_TAPS   = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int IN_WORDS = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int ACC_W    = 2 * WORD_SIZE + 8;
    localparam int XIW      = $clog2(IN_WORDS);
    localparam int KIW      = $clog2(K_TAPS + 1);
    localparam int CIW      = $clog2(CONV_OUT + 1);
    localparam int COW      = (CONV_OUT > 1) ? $clog2(CONV_OUT) : 1;
    localparam int NW       = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
    localparam int CW       = RAM_ADDRESS_BITS;
    localparam int RW       = $clog2(((CONV_OUT > LAYER_HEIGHT) ? CONV_OUT : LAYER_HEIGHT) + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (WORD_SIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, CONV, FC, DONE} state_t;

    state_t state_q, state_d;

    // Weight storage is deliberately left out of reset.
    logic signed [WORD_SIZE-1:0] kmem [K_TAPS+1];
    logic signed [WORD_SIZE-1:0] nmem [LAYER_HEIGHT][CONV_OUT+1];

    logic signed [WORD_SIZE-1:0] x_r    [IN_WORDS];
    logic signed [WORD_SIZE-1:0] conv_r [CONV_OUT];
    logic        [WORD_SIZE-1:0] res_r  [LAYER_HEIGHT];
    logic signed [ACC_W-1:0]     acc_q;
    logic        [CW-1:0]        tap_q;
    logic        [RW-1:0]        row_q;

    logic signed [WORD_SIZE-1:0]   mac_a, mac_b, fin_bias;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]       acc_add;
    logic        [WORD_SIZE-1:0]   fin_val;
    logic                          last_tap, last_row;

    logic [RAM_SELECT_BITS-1:0]  wr_sel;
    logic [RAM_ADDRESS_BITS-1:0] wr_idx;

    // Add the bias at product scale, floor back to N_SIZE fraction bits, clamp.
    function automatic logic [WORD_SIZE-1:0] finalize(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [WORD_SIZE-1:0] bias);
        logic signed [ACC_W-1:0] sum;
        sum = acc + ($signed({{(ACC_W-WORD_SIZE){bias[WORD_SIZE-1]}}, bias}) <<< N_SIZE);
        sum = sum >>> N_SIZE;
        if (sum > SAT_MAX)
            finalize = {1'b0, {(WORD_SIZE-1){1'b1}}};
        else if (sum < SAT_MIN)
            finalize = {1'b1, {(WORD_SIZE-1){1'b0}}};
        else
            finalize = sum[WORD_SIZE-1:0];
    endfunction

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

    assign wr_sel = mem_addr_i[RAM_ADDRESS_BITS +: RAM_SELECT_BITS];
    assign wr_idx = mem_addr_i[RAM_ADDRESS_BITS-1:0];

    always_ff @(posedge clk_i) begin
        if (w_en_i && state_q == IDLE) begin
            if (wr_sel == '0) begin
                if (int'(wr_idx) <= K_TAPS)
                    kmem[KIW'(wr_idx)] <= mem_data_i;
            end else if (int'(wr_sel) <= LAYER_HEIGHT && int'(wr_idx) <= CONV_OUT) begin
                nmem[NW'(int'(wr_sel) - 1)][CIW'(wr_idx)] <= mem_data_i;
            end
        end
    end

    // Each output takes one cycle per tap plus one finalize cycle (last_tap),
    // so the schedule is data independent. In CONV the tap index t walks the
    // kernel row-major, which lines up with input word row*KERNEL_WIDTH + t.
    always_comb begin
        mac_a    = '0;
        mac_b    = '0;
        fin_bias = '0;
        last_tap = 1'b0;
        last_row = 1'b0;
        case (state_q)
            CONV: begin
                last_tap = (int'(tap_q) == K_TAPS);
                last_row = (int'(row_q) == CONV_OUT - 1);
                fin_bias = kmem[0];
                if (!last_tap) begin
                    mac_a = kmem[KIW'(int'(tap_q) + 1)];
                    mac_b = x_r[XIW'(int'(row_q) * KERNEL_WIDTH + int'(tap_q))];
                end
            end
            FC: begin
                last_tap = (int'(tap_q) == CONV_OUT);
                last_row = (int'(row_q) == LAYER_HEIGHT - 1);
                fin_bias = nmem[NW'(row_q)][0];
                if (!last_tap) begin
                    mac_a = nmem[NW'(row_q)][CIW'(int'(tap_q) + 1)];
                    mac_b = conv_r[COW'(tap_q)];
                end
            end
            default: ;
        endcase
    end

    assign prod    = mac_a * mac_b;
    assign acc_add = $signed({{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod});
    assign fin_val = finalize(acc_q, fin_bias);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (valid_i)              state_d = CONV;
            CONV: if (last_tap && last_row) state_d = FC;
            FC:   if (last_tap && last_row) state_d = DONE;
            DONE: if (yumi_i)               state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q  <= '0;
            tap_q  <= '0;
            row_q  <= '0;
            data_o <= '0;
            for (int i = 0; i < IN_WORDS; i++)     x_r[i]    <= '0;
            for (int i = 0; i < CONV_OUT; i++)     conv_r[i] <= '0;
            for (int i = 0; i < LAYER_HEIGHT; i++) res_r[i]  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        for (int i = 0; i < IN_WORDS; i++)
                            x_r[i] <= data_i[i*WORD_SIZE +: WORD_SIZE];
                        acc_q <= '0;
                        tap_q <= '0;
                        row_q <= '0;
                    end
                end
                CONV, FC: begin
                    if (last_tap) begin
                        if (state_q == CONV) begin
                            conv_r[COW'(row_q)] <= fin_val;
                        end else begin
                            res_r[NW'(row_q)] <= fin_val;
                            // data_o only changes here so it holds the previous
                            // result throughout the next computation.
                            if (last_row)
                                for (int n = 0; n < LAYER_HEIGHT; n++)
                                    data_o[n*WORD_SIZE +: WORD_SIZE] <=
                                        (n == LAYER_HEIGHT - 1) ? fin_val : res_r[n];
                        end
                        acc_q <= '0;
                        tap_q <= '0;
                        row_q <= last_row ? '0 : row_q + RW'(1);
                    end else begin
                        acc_q <= acc_q + acc_add;
                        tap_q <= tap_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_fc_layer.sv
// tb/tb_conv_fc_layer.sv - self-checking bench for conv_fc_layer with a behavioural reference model
module tb_conv_fc_layer;

    localparam int WS  = 16;
    localparam int N   = 2;
    localparam int IH  = 5;
    localparam int KH  = 3;
    localparam int KW  = 2;
    localparam int LH  = 2;
    localparam int CO  = IH - KH + 1;
    localparam int KT  = KH * KW;
    localparam int INW = IH * KW;
    localparam int RS  = 2;
    localparam int RA  = 3;
    localparam int LAT_MAX = CO * (KT + 1) + LH * (CO + 1) + 2;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [INW*WS-1:0] data_i = '0;
    logic              valid_o;
    logic              yumi_i = 1'b0;
    logic [LH*WS-1:0]  data_o;
    logic              w_en_i = 1'b0;
    logic [RS+RA-1:0]  mem_addr_i = '0;
    logic [WS-1:0]     mem_data_i = '0;

    int n_pass = 0;
    int n_total = 0;
    int first_lat = -1;

    int kw [KT];
    int kb;
    int nw [LH][CO];
    int nb [LH];

    conv_fc_layer #(
        .WORD_SIZE(WS), .N_SIZE(N), .INPUT_LAYER_HEIGHT(IH), .KERNEL_HEIGHT(KH),
        .KERNEL_WIDTH(KW), .LAYER_HEIGHT(LH)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o),
        .w_en_i(w_en_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Real-valued rule: value = raw / 2^N; sums carry 2N fraction bits.
    function automatic int fin(input longint s, input int b);
        longint d, t, q;
        d = longint'(1) << N;
        t = s + longint'(b) * d;
        q = t / d;
        if ((t % d) != 0 && t < 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic logic [LH*WS-1:0] model(input logic [INW*WS-1:0] v);
        int x [INW];
        int cv [CO];
        longint s;
        logic [LH*WS-1:0] r;
        for (int i = 0; i < INW; i++) x[i] = int'($signed(v[i*WS +: WS]));
        for (int j = 0; j < CO; j++) begin
            s = 0;
            for (int rr = 0; rr < KH; rr++)
                for (int c = 0; c < KW; c++)
                    s += longint'(kw[rr*KW + c]) * longint'(x[(j + rr)*KW + c]);
            cv[j] = fin(s, kb);
        end
        r = '0;
        for (int n = 0; n < LH; n++) begin
            s = 0;
            for (int j = 0; j < CO; j++) s += longint'(nw[n][j]) * longint'(cv[j]);
            r[n*WS +: WS] = 16'(fin(s, nb[n]));
        end
        return r;
    endfunction

    task automatic write_w(input int sel, input int idx, input int d);
        @(negedge clk_i);
        w_en_i     = 1'b1;
        mem_addr_i = {sel[RS-1:0], idx[RA-1:0]};
        mem_data_i = d[WS-1:0];
        @(negedge clk_i);
        w_en_i = 1'b0;
    endtask

    task automatic load_weights();
        write_w(0, 0, kb);
        for (int t = 0; t < KT; t++) write_w(0, t + 1, kw[t]);
        for (int n = 0; n < LH; n++) begin
            write_w(n + 1, 0, nb[n]);
            for (int j = 0; j < CO; j++) write_w(n + 1, j + 1, nw[n][j]);
        end
    endtask

    task automatic set_ref_weights();
        kw = '{4, -6, 8, -8, -6, 4};
        kb = 15;
        nw[0] = '{4, 2, -2};
        nw[1] = '{0, 4, -4};
        nb = '{-2, 2};
    endtask

    task automatic start_vec(input logic [INW*WS-1:0] v);
        int k;
        k = 0;
        @(negedge clk_i);
        while (ready_o !== 1'b1 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check("ready_before_start", ready_o, 1);
        valid_i = 1'b1;
        data_i  = v;
        @(negedge clk_i);
        valid_i = 1'b0;
        data_i  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        check("valid_timeout", valid_o, 1);
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        check("valid_after_yumi", valid_o, 0);
        check("ready_after_yumi", ready_o, 1);
    endtask

    task automatic run(input string tag, input logic [INW*WS-1:0] v);
        int lat;
        start_vec(v);
        wait_valid(lat);
        check("latency_bound", (lat <= LAT_MAX), 1);
        if (first_lat < 0) first_lat = lat;
        else check("latency_fixed", lat, first_lat);
        check(tag, data_o, model(v));
    endtask

    logic [INW*WS-1:0] v_ref;
    logic [INW*WS-1:0] v;
    logic [LH*WS-1:0]  held;
    int lat;

    initial begin
        v_ref = 160'h0006_fffa_fffe_0002_fffa_000e_0002_0008_000a_fffc;

        // Reset state
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("reset_valid", valid_o, 0);
        check("reset_ready", ready_o, 1);
        check("reset_data", data_o, 0);

        // Reference example
        set_ref_weights();
        load_weights();
        run("ref_model", v_ref);
        check("ref_const", data_o, 32'hFFFC_FFE8);
        consume();

        // Randomized weights and inputs
        for (int it = 0; it < 6; it++) begin
            for (int t = 0; t < KT; t++)
                kw[t] = (it >= 4) ? int'($signed(16'($urandom()))) : int'($urandom_range(0, 64)) - 32;
            kb = int'($urandom_range(0, 64)) - 32;
            for (int n = 0; n < LH; n++) begin
                nb[n] = int'($urandom_range(0, 64)) - 32;
                for (int j = 0; j < CO; j++) nw[n][j] = int'($urandom_range(0, 32)) - 16;
            end
            load_weights();
            for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom();
            run("random", v);
            consume();
        end

        // Saturation both ways
        kw = '{4, 4, 4, 4, 4, 4};
        kb = 0;
        nw[0] = '{4, 0, 0};
        nw[1] = '{-4, -4, 0};
        nb = '{0, 0};
        load_weights();
        v = {10{16'h7FFF}};
        run("sat_model", v);
        check("sat_const", data_o, 32'h8000_7FFF);
        consume();

        // Floor rounding of a negative fraction
        kw = '{1, 0, 0, 0, 0, 0};
        nw[0] = '{4, 0, 0};
        nw[1] = '{0, 0, 0};
        load_weights();
        v = '0;
        v[15:0] = 16'hFFFF;
        run("floor_model", v);
        check("floor_word0", data_o[15:0], 16'hFFFF);
        consume();

        // Backpressure: hold result, ignore new input
        set_ref_weights();
        load_weights();
        run("bp_result", v_ref);
        held = data_o;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                valid_i = 1'b1;
                data_i  = {5{$urandom()}};
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            check("bp_data_stable", data_o, held);
            check("bp_ready_low", ready_o, 0);
            check("bp_valid_high", valid_o, 1);
        end
        valid_i = 1'b0;
        consume();
        repeat (40) @(negedge clk_i);
        check("bp_input_ignored", valid_o, 0);
        check("hold_after_yumi", data_o, held);

        // Reset during CONV aborts, weights survive
        start_vec(v_ref);
        repeat (5) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        check("abort_valid_async", valid_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready", ready_o, 1);
        check("abort_valid", valid_o, 0);
        check("abort_data", data_o, 0);
        repeat (40) @(negedge clk_i);
        check("abort_no_result", valid_o, 0);
        run("rerun_after_abort", v_ref);
        check("rerun_const", data_o, 32'hFFFC_FFE8);
        consume();

        // Weight write during FC is ignored
        start_vec(v_ref);
        repeat (CO * (KT + 1) + 2) @(negedge clk_i);
        w_en_i     = 1'b1;
        mem_addr_i = {2'd1, 3'd0};
        mem_data_i = 16'h0100;
        @(negedge clk_i);
        w_en_i = 1'b0;
        wait_valid(lat);
        check("fc_write_current", data_o, 32'hFFFC_FFE8);
        consume();
        run("fc_write_next", v_ref);
        check("fc_write_next_const", data_o, 32'hFFFC_FFE8);
        consume();

        // Out-of-range addresses are ignored
        write_w(3, 1, 16'h7FFF);
        write_w(0, 7, 16'h7FFF);
        write_w(2, 4, 16'h7FFF);
        write_w(1, 5, 16'h7FFF);
        run("oor_model", v_ref);
        check("oor_const", data_o, 32'hFFFC_FFE8);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
